// File: rtl/minmem_tracker_if.sv
// -----------------------------------------------------------------------------
// minmem_tracker_if
//
// Groups the sample stream, the clear strobe, the read port and the commit
// status pulses of minmem_tracker into one bundle.
//
// Handshake: valid-only, no ready. A sample is accepted in every cycle where
// in_valid=1. The tracker never stalls, so the producer owns the pacing. rd_en
// is likewise a one-cycle request. The registered answer arrives with
// rd_valid=1 in the following cycle.
//
// Signals (direction seen from the tracker):
//   in_valid  in   sample present this cycle
//   in_first  in   sample is the first of a row
//   in_last   in   sample is the last of a row; commit the row
//   in_addr   in   row entry written at commit (sampled with in_last)
//   in_data   in   unsigned magnitude
//   clr       in   synchronous clear of memory and running state
//   rd_en     in   read request
//   rd_addr   in   entry to read
//   rd_min1   out  stored min1
//   rd_min2   out  stored min2
//   rd_idx    out  stored min1 index
//   rd_valid  out  read data valid
//   wr_done   out  one-cycle pulse after a successful commit
//   addr_err  out  one-cycle pulse after an out-of-range commit
// -----------------------------------------------------------------------------
interface minmem_tracker_if #(
    parameter int W  = 6,
    parameter int AW = 3,
    parameter int IW = 4
) ();
    logic          in_valid;
    logic          in_first;
    logic          in_last;
    logic [AW-1:0] in_addr;
    logic [W-1:0]  in_data;
    logic          clr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_min1;
    logic [W-1:0]  rd_min2;
    logic [IW-1:0] rd_idx;
    logic          rd_valid;
    logic          wr_done;
    logic          addr_err;

    // The producer / update stage drives samples and read requests.
    modport master (
        output in_valid, in_first, in_last, in_addr, in_data, clr,
        output rd_en, rd_addr,
        input  rd_min1, rd_min2, rd_idx, rd_valid, wr_done, addr_err
    );

    // The tracker consumes samples and answers reads.
    modport slave (
        input  in_valid, in_first, in_last, in_addr, in_data, clr,
        input  rd_en, rd_addr,
        output rd_min1, rd_min2, rd_idx, rd_valid, wr_done, addr_err
    );
endinterface

// File: rtl/minmem_tracker.sv
// -----------------------------------------------------------------------------
// minmem_tracker
//
// Two-minimum tracker and per-row store for the check-node sort stage.
// Magnitudes stream in grouped into rows. For the current row the block keeps
// the smallest value (min1), the second-smallest value (min2), and the
// in-row position of min1. When a row closes (in_last), the result is
// written to mem[in_addr]. A registered read port returns stored entries.
//
// Parameters:
//   W      magnitude width
//   DEPTH  number of row entries
//   AW     address width (2^AW >= DEPTH)
//   IW     min1 index width; the in-row position saturates at 2^IW-1
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    minmem_tracker_if.slave: sample stream, clr, read port and
//          commit status pulses (see the interface file for details)
// -----------------------------------------------------------------------------
module minmem_tracker #(
    parameter int W     = 6,
    parameter int DEPTH = 5,
    parameter int AW    = 3,
    parameter int IW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    minmem_tracker_if.slave bus
);

    localparam logic [W-1:0]  MAX_MAG = {W{1'b1}};
    localparam logic [IW-1:0] MAX_POS = {IW{1'b1}};
    // One extra bit, so that DEPTH itself is representable when AW is tight.
    localparam logic [AW:0]   DEPTH_A = (AW+1)'(DEPTH);

    // ---------------------------------------------------------------------
    // Storage and running state
    // ---------------------------------------------------------------------
    logic [W-1:0]  mem_min1 [DEPTH];
    logic [W-1:0]  mem_min2 [DEPTH];
    logic [IW-1:0] mem_idx  [DEPTH];

    logic [W-1:0]  run_min1;
    logic [W-1:0]  run_min2;
    logic [IW-1:0] run_idx;
    logic [IW-1:0] cnt;

    logic [W-1:0]  rd_min1_q;
    logic [W-1:0]  rd_min2_q;
    logic [IW-1:0] rd_idx_q;
    logic          rd_valid_q;
    logic          wr_done_q;
    logic          addr_err_q;

    // ---------------------------------------------------------------------
    // Sample update
    // ---------------------------------------------------------------------
    // in_first restarts the search from MAX regardless of what the running
    // registers hold. A row may therefore begin without a preceding in_last.
    logic [W-1:0]  eff_min1;
    logic [W-1:0]  eff_min2;
    logic [IW-1:0] eff_idx;
    logic [IW-1:0] pos;

    logic [W-1:0]  nxt_min1;
    logic [W-1:0]  nxt_min2;
    logic [IW-1:0] nxt_idx;
    logic [IW-1:0] nxt_cnt;

    always_comb begin
        eff_min1 = run_min1;
        eff_min2 = run_min2;
        eff_idx  = run_idx;
        pos      = cnt;
        if (bus.in_first) begin
            eff_min1 = MAX_MAG;
            eff_min2 = MAX_MAG;
            eff_idx  = '0;
            pos      = '0;
        end

        nxt_min1 = eff_min1;
        nxt_min2 = eff_min2;
        nxt_idx  = eff_idx;
        // Strict compares: a value equal to min1 lands in min2, so min1
        // keeps the index of its earliest occurrence.
        if (bus.in_data < eff_min1) begin
            nxt_min2 = eff_min1;
            nxt_min1 = bus.in_data;
            nxt_idx  = pos;
        end else if (bus.in_data < eff_min2) begin
            nxt_min2 = bus.in_data;
        end

        // Long rows pin the position at the top code instead of wrapping.
        // Any later new minimum is then reported at index 2^IW-1.
        nxt_cnt = (pos == MAX_POS) ? pos : pos + 1'b1;
    end

    // ---------------------------------------------------------------------
    // Commit decode
    // ---------------------------------------------------------------------
    // clr wins over a sample in the same cycle. The sample, including any
    // commit it carries, is dropped.
    logic accept;
    logic commit;
    logic wr_addr_ok;
    logic rd_addr_ok;

    assign accept     = bus.in_valid & ~bus.clr;
    assign commit     = accept & bus.in_last;
    assign wr_addr_ok = ({1'b0, bus.in_addr} < DEPTH_A);
    assign rd_addr_ok = ({1'b0, bus.rd_addr} < DEPTH_A);

    // ---------------------------------------------------------------------
    // Running state registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_min1 <= MAX_MAG;
            run_min2 <= MAX_MAG;
            run_idx  <= '0;
            cnt      <= '0;
        end else if (bus.clr) begin
            run_min1 <= MAX_MAG;
            run_min2 <= MAX_MAG;
            run_idx  <= '0;
            cnt      <= '0;
        end else if (accept) begin
            if (bus.in_last) begin
                // The row is closed, even when its address is out of range.
                run_min1 <= MAX_MAG;
                run_min2 <= MAX_MAG;
                run_idx  <= '0;
                cnt      <= '0;
            end else begin
                run_min1 <= nxt_min1;
                run_min2 <= nxt_min2;
                run_idx  <= nxt_idx;
                cnt      <= nxt_cnt;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Row memory
    // ---------------------------------------------------------------------
    // The commit writes the post-update values of the closing sample. A row
    // of one sample (first+last) therefore stores in_data/MAX/0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_min1[i] <= '0;
                mem_min2[i] <= '0;
                mem_idx[i]  <= '0;
            end
        end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_min1[i] <= '0;
                mem_min2[i] <= '0;
                mem_idx[i]  <= '0;
            end
        end else if (commit && wr_addr_ok) begin
            mem_min1[bus.in_addr] <= nxt_min1;
            mem_min2[bus.in_addr] <= nxt_min2;
            mem_idx[bus.in_addr]  <= nxt_idx;
        end
    end

    // ---------------------------------------------------------------------
    // Commit status pulses
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_done_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            wr_done_q  <= commit &  wr_addr_ok;
            addr_err_q <= commit & ~wr_addr_ok;
        end
    end

    // ---------------------------------------------------------------------
    // Read port
    // ---------------------------------------------------------------------
    // The read samples the memory array before this edge's write or clear
    // lands. A same-edge commit or clr is therefore seen only by the next
    // read. clr does not touch the read registers themselves. Out-of-range
    // reads are steered to entry 0 and then masked to zero, so the array is
    // never indexed out of bounds.
    logic [AW-1:0] rd_sel;

    assign rd_sel = rd_addr_ok ? bus.rd_addr : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_min1_q  <= '0;
            rd_min2_q  <= '0;
            rd_idx_q   <= '0;
            rd_valid_q <= 1'b0;
        end else if (bus.rd_en) begin
            rd_valid_q <= 1'b1;
            if (rd_addr_ok) begin
                rd_min1_q <= mem_min1[rd_sel];
                rd_min2_q <= mem_min2[rd_sel];
                rd_idx_q  <= mem_idx[rd_sel];
            end else begin
                rd_min1_q <= '0;
                rd_min2_q <= '0;
                rd_idx_q  <= '0;
            end
        end else begin
            // Data holds its last value. Only the valid flag drops.
            rd_valid_q <= 1'b0;
        end
    end

    assign bus.rd_min1  = rd_min1_q;
    assign bus.rd_min2  = rd_min2_q;
    assign bus.rd_idx   = rd_idx_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_done  = wr_done_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_minmem_tracker.sv
// -----------------------------------------------------------------------------
// tb_minmem_tracker
//
// Directed scenarios followed by a randomized stream for minmem_tracker.
// The reference model keeps each open row as a plain list of samples. At
// commit it sorts a copy of that list to obtain min1/min2. min1's index is
// the first position of the smallest value, capped at 2^IW-1.
// -----------------------------------------------------------------------------
module tb_minmem_tracker;

    localparam int W     = 6;
    localparam int DEPTH = 5;
    localparam int AW    = 3;
    localparam int IW    = 4;
    localparam logic [W-1:0]  MAX_MAG = {W{1'b1}};
    localparam int            MAX_POS = (1 << IW) - 1;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    minmem_tracker_if #(.W(W), .AW(AW), .IW(IW)) bus ();

    minmem_tracker #(.W(W), .DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------------------------------------------------------------
    // Reference model / scoreboard
    // ---------------------------------------------------------------------
    int            n_cmp = 0;
    int            n_bad = 0;

    logic [W-1:0]  m_min1 [DEPTH];
    logic [W-1:0]  m_min2 [DEPTH];
    logic [IW-1:0] m_idx  [DEPTH];
    int            row_q[$];

    logic [W-1:0]  e_rd_min1;
    logic [W-1:0]  e_rd_min2;
    logic [IW-1:0] e_rd_idx;
    logic          e_rd_valid;
    logic          e_wr_done;
    logic          e_addr_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_min1[i] = '0;
            m_min2[i] = '0;
            m_idx[i]  = '0;
        end
        row_q.delete();
        e_rd_min1  = '0;
        e_rd_min2  = '0;
        e_rd_idx   = '0;
        e_rd_valid = 1'b0;
        e_wr_done  = 1'b0;
        e_addr_err = 1'b0;
    endtask

    function automatic void row_result(output logic [W-1:0] m1, output logic [W-1:0] m2,
                                       output logic [IW-1:0] ix);
        int s[$];
        int first;
        s = row_q;
        s.sort();
        m1 = W'(s[0]);
        m2 = (s.size() > 1) ? W'(s[1]) : MAX_MAG;
        first = 0;
        for (int i = 0; i < row_q.size(); i++) begin
            if (row_q[i] == s[0]) begin
                first = i;
                break;
            end
        end
        ix = (first > MAX_POS) ? IW'(MAX_POS) : IW'(first);
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(e_rd_valid));
        chk({tag, ".rd_min1"},  32'(bus.rd_min1),  32'(e_rd_min1));
        chk({tag, ".rd_min2"},  32'(bus.rd_min2),  32'(e_rd_min2));
        chk({tag, ".rd_idx"},   32'(bus.rd_idx),   32'(e_rd_idx));
        chk({tag, ".wr_done"},  32'(bus.wr_done),  32'(e_wr_done));
        chk({tag, ".addr_err"}, 32'(bus.addr_err), 32'(e_addr_err));
    endtask

    // ---------------------------------------------------------------------
    // Driver tasks. Each call is entered about 1 time unit after a rising
    // edge. It drives one cycle, advances the model, and checks #1 after
    // the next edge.
    // ---------------------------------------------------------------------
    task automatic cyc(input string tag, input logic v, input logic f, input logic l,
                       input logic [AW-1:0] a, input logic [W-1:0] d, input logic c,
                       input logic re, input logic [AW-1:0] ra);
        logic [W-1:0]  r1;
        logic [W-1:0]  r2;
        logic [IW-1:0] rx;
        bus.in_valid = v;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.clr      = c;
        bus.rd_en    = re;
        bus.rd_addr  = ra;

        // The read answer reflects memory as it stands before this edge.
        if (re) begin
            e_rd_valid = 1'b1;
            if (int'(ra) < DEPTH) begin
                e_rd_min1 = m_min1[ra];
                e_rd_min2 = m_min2[ra];
                e_rd_idx  = m_idx[ra];
            end else begin
                e_rd_min1 = '0;
                e_rd_min2 = '0;
                e_rd_idx  = '0;
            end
        end else begin
            e_rd_valid = 1'b0;
        end

        e_wr_done  = 1'b0;
        e_addr_err = 1'b0;
        if (c) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_min1[i] = '0;
                m_min2[i] = '0;
                m_idx[i]  = '0;
            end
            row_q.delete();
        end else if (v) begin
            if (f) row_q.delete();
            row_q.push_back(int'(d));
            if (l) begin
                row_result(r1, r2, rx);
                if (int'(a) < DEPTH) begin
                    m_min1[a] = r1;
                    m_min2[a] = r2;
                    m_idx[a]  = rx;
                    e_wr_done = 1'b1;
                end else begin
                    e_addr_err = 1'b1;
                end
                row_q.delete();
            end
        end

        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic smp(input string tag, input logic f, input logic l,
                       input logic [AW-1:0] a, input logic [W-1:0] d);
        cyc(tag, 1'b1, f, l, a, d, 1'b0, 1'b0, '0);
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] ra);
        cyc(tag, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, ra);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from the clock edge.
    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs(tag);
        #2;
        reset = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        logic          rv, rf, rl, rc, rre;
        logic [AW-1:0] ra, rra;
        logic [W-1:0]  rdat;

        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.clr      = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        model_reset();
        #3;
        check_outputs("reset");
        #9;
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle("post_reset");

        // Row 20,7,33,7,50 to entry 2: the tie on 7 lands in min2.
        smp("r1_s0", 1'b1, 1'b0, 3'd0, 6'd20);
        smp("r1_s1", 1'b0, 1'b0, 3'd0, 6'd7);
        smp("r1_s2", 1'b0, 1'b0, 3'd0, 6'd33);
        smp("r1_s3", 1'b0, 1'b0, 3'd0, 6'd7);
        smp("r1_s4", 1'b0, 1'b1, 3'd2, 6'd50);
        chk("r1_wr_done", 32'(bus.wr_done), 32'd1);
        rd("r1_rd", 3'd2);
        chk("r1_min1", 32'(bus.rd_min1), 32'd7);
        chk("r1_min2", 32'(bus.rd_min2), 32'd7);
        chk("r1_idx",  32'(bus.rd_idx),  32'd1);

        // Single-sample row, then an untouched entry.
        smp("r2_s0", 1'b1, 1'b1, 3'd0, 6'd12);
        rd("r2_rd0", 3'd0);
        chk("r2_min2", 32'(bus.rd_min2), 32'd63);
        rd("r2_rd1", 3'd1);
        chk("r2_untouched", 32'(bus.rd_min1), 32'd0);

        // Out-of-range commit, then a normal row to entry 4.
        smp("r3_s0", 1'b1, 1'b0, 3'd0, 6'd9);
        smp("r3_s1", 1'b0, 1'b0, 3'd0, 6'd4);
        smp("r3_s2", 1'b0, 1'b1, 3'd6, 6'd1);
        chk("r3_addr_err", 32'(bus.addr_err), 32'd1);
        for (int i = 0; i < DEPTH; i++) rd("r3_rd", AW'(i));
        smp("r4_s0", 1'b1, 1'b0, 3'd0, 6'd5);
        smp("r4_s1", 1'b0, 1'b1, 3'd4, 6'd3);
        rd("r4_rd", 3'd4);
        chk("r4_idx", 32'(bus.rd_idx), 32'd1);

        // Read entry 3 on the same edge as its commit: the old content comes back.
        smp("r5_s0", 1'b1, 1'b0, 3'd0, 6'd8);
        cyc("r5_s1_rd", 1'b1, 1'b0, 1'b1, 3'd3, 6'd2, 1'b0, 1'b1, 3'd3);
        chk("r5_old_min1", 32'(bus.rd_min1), 32'd0);
        rd("r5_rd", 3'd3);
        chk("r5_new_min2", 32'(bus.rd_min2), 32'd8);

        // Reset in the middle of a row discards the partial row.
        smp("r6_s0", 1'b1, 1'b0, 3'd0, 6'd10);
        smp("r6_s1", 1'b0, 1'b0, 3'd0, 6'd3);
        pulse_reset("r6_reset");
        smp("r7_s0", 1'b1, 1'b0, 3'd0, 6'd6);
        smp("r7_s1", 1'b0, 1'b1, 3'd1, 6'd9);
        rd("r7_rd", 3'd1);
        chk("r7_min1", 32'(bus.rd_min1), 32'd6);

        // clr on the last sample: no write and no wr_done; every entry reads 0.
        smp("r8_s0", 1'b1, 1'b0, 3'd0, 6'd4);
        cyc("r8_clr", 1'b1, 1'b0, 1'b1, 3'd0, 6'd1, 1'b1, 1'b1, 3'd1);
        chk("r8_pre_clear_read", 32'(bus.rd_min1), 32'd6);
        for (int i = 0; i < DEPTH; i++) rd("r8_rd", AW'(i));

        // Index saturation: 20 strictly decreasing samples.
        for (int i = 0; i < 20; i++)
            smp("r9_s", (i == 0), (i == 19), 3'd2, W'(63 - i));
        rd("r9_rd", 3'd2);
        chk("r9_idx",  32'(bus.rd_idx),  32'd15);
        chk("r9_min1", 32'(bus.rd_min1), 32'd44);
        chk("r9_min2", 32'(bus.rd_min2), 32'd45);

        // Randomized stream, including out-of-range addresses and ties.
        for (int n = 0; n < 400; n++) begin
            rv   = ($urandom_range(0, 3) != 0);
            rf   = ($urandom_range(0, 4) == 0);
            rl   = ($urandom_range(0, 4) == 0);
            ra   = AW'($urandom_range(0, 7));
            rdat = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 63))
                                               : W'($urandom_range(0, 7));
            rc   = ($urandom_range(0, 40) == 0);
            rre  = ($urandom_range(0, 1) == 1);
            rra  = AW'($urandom_range(0, 7));
            cyc("rand", rv, rf, rl, ra, rdat, rc, rre, rra);
        end
        for (int i = 0; i < DEPTH; i++) rd("final_rd", AW'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
